// File: rtl/sdram_page_writer.sv
// Page-program/erase engine: stages flash page bytes, then commits bursts to SDRAM
// (read-modify-write for partial bursts). Optional macro FLASH_AND_EN selects NOR-flash AND semantics.
module sdram_page_writer #(
    parameter int          DATA_W     = 64,
    parameter int          PAGE_BYTES = 256,
    parameter int          ADDR_W     = 22,
    parameter int          LEN_W      = 13,
    parameter logic [7:0]  ERASE_FILL = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          buf_we,
    input  logic [$clog2(PAGE_BYTES)-1:0] buf_offset,
    input  logic [7:0]                    buf_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_erase,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    sdram_access_cmd,
    output logic [ADDR_W+1:0]             sdram_access_addr,
    input  logic                          sdram_cmd_busy,
    input  logic [DATA_W-1:0]             sdram_read_buffer,
    output logic [DATA_W-1:0]             sdram_write_buffer
);

    localparam int BPB   = DATA_W / 8;
    localparam int PB    = PAGE_BYTES / BPB;
    localparam int OFF_W = $clog2(PAGE_BYTES);
    localparam int PB_W  = $clog2(PB);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ACT = 2'b11;

`ifdef FLASH_AND_EN
    localparam bit RMW_ALWAYS = 1'b1;
`else
    localparam bit RMW_ALWAYS = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, PREP, ACT_RD, RD, MERGE, ACT_WR, WR, NEXT
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic               erase_q;
    logic [DATA_W-1:0]  wbuf;
    logic [BPB-1:0]     mask_q;

    logic [7:0]         stage_mem [PAGE_BYTES];
    logic [PAGE_BYTES-1:0] valid_q;

    logic               sdram_busy;
    logic               accept;
    logic [PB_W-1:0]    page_idx;
    logic [OFF_W-1:0]   burst_base;
    logic [DATA_W-1:0]  stage_burst;
    logic [BPB-1:0]     stage_mask;
    logic [DATA_W-1:0]  merged;

    logic [1:0]         cmd_nx;
    logic               done_nx;
    logic               load_burst;
    logic               merge_en;
    logic               fill_en;
    logic               step;

    assign sdram_busy = (sdram_access_cmd != CMD_NOP) || sdram_cmd_busy;
    assign cmd_ready  = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign page_idx   = addr_q[PB_W-1:0];
    assign burst_base = OFF_W'(page_idx * BPB);

    always_comb begin
        stage_burst = '0;
        stage_mask  = '0;
        for (int i = 0; i < BPB; i++) begin
            stage_burst[8*i +: 8] = stage_mem[burst_base + OFF_W'(i)];
            stage_mask[i]         = valid_q[burst_base + OFF_W'(i)];
        end
    end

    // Unstaged bytes always come from SDRAM; staged bytes replace (or AND into) the old data.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BPB; i++) begin
`ifdef FLASH_AND_EN
            merged[8*i +: 8] = mask_q[i] ? (wbuf[8*i +: 8] & sdram_read_buffer[8*i +: 8])
                                         : sdram_read_buffer[8*i +: 8];
`else
            merged[8*i +: 8] = mask_q[i] ? wbuf[8*i +: 8] : sdram_read_buffer[8*i +: 8];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: default every comb output first so no path leaves a variable unassigned (latch).
        state_nx = state;
        unique case (state)
            IDLE:   if (accept) state_nx = cmd_erase ? ACT_WR : PREP;
            PREP: begin
                if (stage_mask == '0)                     state_nx = NEXT;
                else if (stage_mask == '1 && !RMW_ALWAYS) state_nx = ACT_WR;
                else                                      state_nx = ACT_RD;
            end
            ACT_RD: if (!sdram_busy) state_nx = RD;
            RD:     if (!sdram_busy) state_nx = MERGE;
            MERGE:  if (!sdram_busy) state_nx = ACT_WR;
            ACT_WR: if (!sdram_busy) state_nx = WR;
            WR:     if (!sdram_busy) state_nx = NEXT;
            NEXT: begin
                if (!sdram_busy) begin
                    if (len_q == '0) state_nx = IDLE;
                    else             state_nx = erase_q ? ACT_WR : PREP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_nx     = CMD_NOP;
        done_nx    = 1'b0;
        load_burst = 1'b0;
        merge_en   = 1'b0;
        fill_en    = 1'b0;
        step       = 1'b0;
        unique case (state)
            PREP:   load_burst = 1'b1;
            ACT_RD: if (!sdram_busy) cmd_nx = CMD_ACT;
            RD:     if (!sdram_busy) cmd_nx = CMD_RD;
            MERGE:  merge_en = !sdram_busy;
            ACT_WR: begin
                if (!sdram_busy) begin
                    cmd_nx  = CMD_ACT;
                    fill_en = erase_q;
                end
            end
            WR:     if (!sdram_busy) cmd_nx = CMD_WR;
            NEXT: begin
                if (!sdram_busy) begin
                    done_nx = (len_q == '0);
                    step    = (len_q != '0);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_access_cmd   <= CMD_NOP;
            done               <= 1'b0;
            sdram_access_addr  <= '0;
            sdram_write_buffer <= '0;
        end else begin
            sdram_access_cmd   <= cmd_nx;
            done               <= done_nx;
            sdram_access_addr  <= {addr_q, 2'b00};
            sdram_write_buffer <= wbuf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            len_q   <= '0;
            erase_q <= 1'b0;
            wbuf    <= '0;
            mask_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                erase_q <= cmd_erase;
            end
            if (step) begin
                addr_q <= addr_q + ADDR_W'(1);
                len_q  <= len_q - LEN_W'(1);
            end
            if (load_burst) begin
                wbuf   <= stage_burst;
                mask_q <= stage_mask;
            end
            if (fill_en)  wbuf <= {BPB{ERASE_FILL}};
            if (merge_en) wbuf <= merged;
        end
    end

    // NOTE: the byte store has no reset; the valid bits alone decide whether a byte is staged.
    always_ff @(posedge clk) begin
        if (buf_we) stage_mem[buf_offset] <= buf_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (load_burst) valid_q[burst_base +: BPB] <= '0;
            // A same-cycle staging write lands after the clear, so the byte stays valid.
            if (buf_we)     valid_q[buf_offset] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_page_writer.sv
// Directed bench for sdram_page_writer: small SDRAM busy model, command log and hand-computed expectations.
module tb_sdram_page_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        buf_we;
    logic [7:0]  buf_offset;
    logic [7:0]  buf_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_erase;
    logic [21:0] cmd_addr;
    logic [12:0] cmd_len;
    logic        busy;
    logic        done;
    logic [1:0]  sdram_access_cmd;
    logic [23:0] sdram_access_addr;
    logic        sdram_cmd_busy = 1'b0;
    logic [63:0] sdram_read_buffer;
    logic [63:0] sdram_write_buffer;

    sdram_page_writer dut (
        .clk                (clk),
        .reset              (reset),
        .buf_we             (buf_we),
        .buf_offset         (buf_offset),
        .buf_data           (buf_data),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_erase          (cmd_erase),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .busy               (busy),
        .done               (done),
        .sdram_access_cmd   (sdram_access_cmd),
        .sdram_access_addr  (sdram_access_addr),
        .sdram_cmd_busy     (sdram_cmd_busy),
        .sdram_read_buffer  (sdram_read_buffer),
        .sdram_write_buffer (sdram_write_buffer)
    );

    always #5 clk = ~clk;

`ifdef FLASH_AND_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int          neg_cyc = 0;
    int          n_act = 0, n_rd = 0, n_wr = 0, n_done = 0;
    logic [63:0] last_wr_data = '0;
    logic [23:0] last_wr_addr = '0;
    int          b_act, b_rd, b_wr, b_done;
    int          busy_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Controller model: stays busy for two sampled cycles after any command.
    always @(negedge clk) begin
        if (sdram_access_cmd != 2'b00)  busy_cnt = 2;
        else if (busy_cnt > 0)          busy_cnt = busy_cnt - 1;
        sdram_cmd_busy = (busy_cnt != 0);
    end

    always @(negedge clk) begin
        neg_cyc <= neg_cyc + 1;
        if (sdram_access_cmd == 2'b11) n_act <= n_act + 1;
        if (sdram_access_cmd == 2'b01) n_rd  <= n_rd + 1;
        if (sdram_access_cmd == 2'b10) begin
            n_wr         <= n_wr + 1;
            last_wr_data <= sdram_write_buffer;
            last_wr_addr <= sdram_access_addr;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic snap();
        b_act = n_act; b_rd = n_rd; b_wr = n_wr; b_done = n_done;
    endtask

    task automatic check_counts(input string tag, input int a, input int r, input int w);
        check({tag, "_act"},  64'(n_act - b_act), 64'(a));
        check({tag, "_rd"},   64'(n_rd - b_rd),   64'(r));
        check({tag, "_wr"},   64'(n_wr - b_wr),   64'(w));
        check({tag, "_done"}, 64'(n_done - b_done), 64'd1);
    endtask

    task automatic stage(input logic [7:0] off, input logic [7:0] d);
        @(negedge clk);
        buf_we = 1'b1; buf_offset = off; buf_data = d;
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    task automatic issue(input logic erase, input logic [21:0] addr, input logic [12:0] len, output int k);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_erase = erase; cmd_addr = addr; cmd_len = len;
        k = neg_cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_act(input string tag, output int when, output logic [23:0] addr);
        bit seen = 0;
        when = -1; addr = '0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (sdram_access_cmd == 2'b11) begin
                seen = 1; when = neg_cyc; addr = sdram_access_addr;
            end
        end
        check({tag, "_act_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag, output int when);
        bit seen = 0;
        when = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; when = neg_cyc; end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, ta, td;
        logic [23:0] aa;

        reset = 1'b1; buf_we = 1'b0; buf_offset = '0; buf_data = '0;
        cmd_valid = 1'b0; cmd_erase = 1'b0; cmd_addr = '0; cmd_len = '0;
        sdram_read_buffer = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_cmd",   64'(sdram_access_cmd), 64'd0);
        check("rst_addr",  64'(sdram_access_addr), 64'd0);
        check("rst_wbuf",  sdram_write_buffer, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Erase two bursts starting at 0x10
        snap();
        issue(1'b1, 22'h000010, 13'd1, k);
        wait_act("erase", ta, aa);
        check("erase_lat",   64'(ta - k), 64'd2);
        check("erase_addr0", 64'(aa), 64'h40);
        check("erase_busy",  64'(busy), 64'd1);
        wait_done("erase", td);
        check_counts("erase", 2, 0, 2);
        check("erase_data",  last_wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("erase_waddr", 64'(last_wr_addr), 64'h44);
        check("erase_ready", 64'(cmd_ready), 64'd1);

        // Full burst at page burst 1
        for (int i = 0; i < 8; i++) stage(8'(8 + i), 8'(i));
        sdram_read_buffer = 64'hFFFF_FFFF_FFFF_FFFF;
        snap();
        issue(1'b0, 22'h000001, 13'd0, k);
        wait_act("full", ta, aa);
        check("full_lat", 64'(ta - k), 64'd3);
        wait_done("full", td);
        check_counts("full", FLASH ? 2 : 1, FLASH ? 1 : 0, 1);
        check("full_data",  last_wr_data, 64'h0706_0504_0302_0100);
        check("full_waddr", 64'(last_wr_addr), 64'h4);

        // Same burst again: its valid bits were cleared, so nothing is issued
        snap();
        issue(1'b0, 22'h000001, 13'd0, k);
        wait_done("recheck", td);
        check_counts("recheck", 0, 0, 0);

        // Partial burst read-modify-write
        stage(8'd17, 8'hAB);
        sdram_read_buffer = 64'h1122_3344_5566_7788;
        snap();
        issue(1'b0, 22'h000002, 13'd0, k);
        wait_act("rmw", ta, aa);
        check("rmw_lat", 64'(ta - k), 64'd3);
        wait_done("rmw", td);
        check_counts("rmw", 2, 1, 1);
        check("rmw_data",  last_wr_data, FLASH ? 64'h1122_3344_5566_2388 : 64'h1122_3344_5566_AB88);
        check("rmw_waddr", 64'(last_wr_addr), 64'h8);

        // Empty burst: no traffic, done two cycles after accept
        snap();
        issue(1'b0, 22'h000003, 13'd0, k);
        wait_done("empty", td);
        check("empty_lat", 64'(td - k), 64'd3);
        check_counts("empty", 0, 0, 0);

        // Run past the page end: 31 empty, 32 wraps to page burst 0, 33 already cleared
        stage(8'd0, 8'h5A);
        snap();
        issue(1'b0, 22'h00001F, 13'd2, k);
        wait_done("wrap_pg", td);
        check_counts("wrap_pg", 2, 1, 1);
        check("wrap_pg_data",  last_wr_data, FLASH ? 64'h1122_3344_5566_7708 : 64'h1122_3344_5566_775A);
        check("wrap_pg_waddr", 64'(last_wr_addr), 64'h80);

        // Erase across the top of the address space
        snap();
        issue(1'b1, 22'h3FFFFF, 13'd1, k);
        wait_act("wrap_ad", ta, aa);
        check("wrap_ad_addr0", 64'(aa), 64'hFF_FFFC);
        wait_done("wrap_ad", td);
        check_counts("wrap_ad", 2, 0, 2);
        check("wrap_ad_waddr", 64'(last_wr_addr), 64'h0);

        // Full mask with staged 0x0F over old 0xF3
        stage(8'd48, 8'h0F);
        for (int i = 1; i < 8; i++) stage(8'(48 + i), 8'hFF);
        sdram_read_buffer = 64'hFFFF_FFFF_FFFF_FFF3;
        snap();
        issue(1'b0, 22'h000006, 13'd0, k);
        wait_done("nor", td);
        check_counts("nor", FLASH ? 2 : 1, FLASH ? 1 : 0, 1);
        check("nor_data", last_wr_data, FLASH ? 64'hFFFF_FFFF_FFFF_FF03 : 64'hFFFF_FFFF_FFFF_FF0F);

        // Reset between ACT_WR and WR
        stage(8'd40, 8'h77);
        snap();
        issue(1'b1, 22'h000005, 13'd0, k);
        wait_act("mid_rst", ta, aa);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(cmd_ready), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_cmd",   64'(sdram_access_cmd), 64'd0);
        check("mid_rst_addr",  64'(sdram_access_addr), 64'd0);
        check("mid_rst_wbuf",  sdram_write_buffer, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 64'(cmd_ready), 64'd1);
        repeat (10) @(negedge clk);
        check("mid_rst_no_wr",   64'(n_wr - b_wr), 64'd0);
        check("mid_rst_no_done", 64'(n_done - b_done), 64'd0);

        // Byte 40 was staged before the reset; it must now be gone
        snap();
        issue(1'b0, 22'h000005, 13'd0, k);
        wait_done("post_rst", td);
        check_counts("post_rst", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
